// File: rtl/pfclk_gtx_bringup_seq.sv
// pfclk_gtx_bringup_seq
//   Bring-up and recovery sequencer for the PF clock-forwarding GTX transmitter.
//   Sequence: CPLL reset pulse -> stable CPLL lock -> stable MMCM lock -> GTX TX soft-reset
//   pulse -> txuserrdy -> stable TX reset-done -> RUN. Loss of any lock/done while bringing up
//   or running causes a bounded re-sequence; exhausting MAX_RETRY parks the block in FAULT
//   until soft_reset.
//
// Ports
//   clk_125        in   free-running system clock, rising edge
//   soft_reset     in   synchronous active-high reset
//   cpll_lock      in   GTX CPLL lock (asynchronous)
//   mmcm_lock      in   link-clock MMCM lock (asynchronous)
//   tx_done        in   GTX TX FSM reset-done (asynchronous)
//   cpll_reset_out out  GTX CPLL reset
//   gtx_reset_out  out  GTX TX soft reset
//   txuserrdy_out  out  GTX txuserrdy / data_valid
//   link_up        out  high only in RUN
//   fault          out  high only in FAULT (sticky)
//   state_out      out  state encoding 0..7
//   retry_cnt      out  failed attempts since last RUN entry
//   lockloss_cnt   out  RUN->failure count (only with PFCLK_SEQ_LOSSCNT_EN)
//
// Configuration macro: PFCLK_SEQ_LOSSCNT_EN adds the lockloss_cnt output and counter.

module pfclk_gtx_bringup_seq #(
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned STABLE_CYC       = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 125000,
   parameter int unsigned MAX_RETRY        = 4
) (
   input  logic        clk_125,
   input  logic        soft_reset,
   input  logic        cpll_lock,
   input  logic        mmcm_lock,
   input  logic        tx_done,
   output logic        cpll_reset_out,
   output logic        gtx_reset_out,
   output logic        txuserrdy_out,
   output logic        link_up,
   output logic        fault,
   output logic [2:0]  state_out,
   output logic [3:0]  retry_cnt
`ifdef PFCLK_SEQ_LOSSCNT_EN
   ,
   output logic [15:0] lockloss_cnt
`endif
);

   localparam int unsigned PW = $clog2(RST_PULSE_CYC) + 1;
   localparam int unsigned SW = $clog2(STABLE_CYC) + 1;
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYC) + 1;

   localparam logic [PW-1:0] PulseLast   = PW'(RST_PULSE_CYC - 1);
   localparam logic [SW-1:0] StableDone  = SW'(STABLE_CYC);
   localparam logic [TW-1:0] TimeoutDone = TW'(LOCK_TIMEOUT_CYC);
   localparam logic [3:0]    RetryLimit  = 4'(MAX_RETRY);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StCpllRst  = 3'd1;
   localparam logic [2:0] StCpllWait = 3'd2;
   localparam logic [2:0] StMmcmWait = 3'd3;
   localparam logic [2:0] StTxRst    = 3'd4;
   localparam logic [2:0] StTxWait   = 3'd5;
   localparam logic [2:0] StRun      = 3'd6;
   localparam logic [2:0] StFault    = 3'd7;

   // Two-flop synchronisers
   logic cpll_meta_q, cpll_s_q;
   logic mmcm_meta_q, mmcm_s_q;
   logic tx_meta_q, tx_s_q;

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pulse_q, pulse_d;
   logic [SW-1:0] stable_q, stable_d, stable_inc;
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
   logic [3:0]    retry_q, retry_d;
   logic          watch_s, guard_ok, fail;

   logic cpll_rst_q, cpll_rst_d;
   logic gtx_rst_q, gtx_rst_d;
   logic rdy_q, rdy_d;
   logic link_q, link_d;
   logic fault_q, fault_d;

   // Which synchronised input each state waits on, and which must stay high meanwhile.
   always_comb begin
      watch_s  = 1'b0;
      guard_ok = 1'b1;
      case (state_q)
         StCpllWait: watch_s = cpll_s_q;
         StMmcmWait: begin
            watch_s  = mmcm_s_q;
            guard_ok = cpll_s_q;
         end
         StTxWait: begin
            watch_s  = tx_s_q;
            guard_ok = cpll_s_q & mmcm_s_q;
         end
         StRun:   guard_ok = cpll_s_q & mmcm_s_q & tx_s_q;
         default: ;
      endcase
   end

   always_comb begin
      stable_inc = watch_s ? stable_q + SW'(1) : '0;
      tmo_inc    = tmo_q + TW'(1);
      state_d    = state_q;
      fail       = 1'b0;
      case (state_q)
         StIdle:    state_d = StCpllRst;
         StCpllRst: if (pulse_q == PulseLast) state_d = StCpllWait;
         StTxRst:   if (pulse_q == PulseLast) state_d = StTxWait;
         StCpllWait, StMmcmWait, StTxWait: begin
            // Lock loss beats a completing stable count; a completing count beats timeout.
            if (!guard_ok) begin
               fail = 1'b1;
            end else if (stable_inc == StableDone) begin
               case (state_q)
                  StCpllWait: state_d = StMmcmWait;
                  StMmcmWait: state_d = StTxRst;
                  default:    state_d = StRun;
               endcase
            end else if (tmo_inc == TimeoutDone) begin
               fail = 1'b1;
            end
         end
         StRun:   if (!guard_ok) fail = 1'b1;
         default: ;
      endcase

      retry_d = retry_q;
      if (fail) begin
         retry_d = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
         state_d = (retry_d >= RetryLimit) ? StFault : StCpllRst;
      end else if (state_d == StRun && state_q != StRun) begin
         retry_d = '0;
      end

      // Every counter restarts on a state change, so each phase times itself from entry.
      pulse_d  = '0;
      stable_d = '0;
      tmo_d    = '0;
      if (state_d == state_q) begin
         if (state_q == StCpllRst || state_q == StTxRst) pulse_d = pulse_q + PW'(1);
         if (state_q == StCpllWait || state_q == StMmcmWait || state_q == StTxWait) begin
            stable_d = stable_inc;
            tmo_d    = tmo_inc;
         end
      end
   end

   // Outputs are registered from the next state so they line up with state_out.
   always_comb begin
      cpll_rst_d = state_d inside {StIdle, StCpllRst, StFault};
      gtx_rst_d  = state_d inside {StIdle, StCpllRst, StCpllWait, StMmcmWait, StTxRst, StFault};
      rdy_d      = state_d inside {StTxWait, StRun};
      link_d     = (state_d == StRun);
      fault_d    = (state_d == StFault);
   end

   always_ff @(posedge clk_125) begin
      if (soft_reset) begin
         cpll_meta_q <= 1'b0;
         cpll_s_q    <= 1'b0;
         mmcm_meta_q <= 1'b0;
         mmcm_s_q    <= 1'b0;
         tx_meta_q   <= 1'b0;
         tx_s_q      <= 1'b0;
         state_q     <= StIdle;
         pulse_q     <= '0;
         stable_q    <= '0;
         tmo_q       <= '0;
         retry_q     <= '0;
         cpll_rst_q  <= 1'b1;
         gtx_rst_q   <= 1'b1;
         rdy_q       <= 1'b0;
         link_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         cpll_meta_q <= cpll_lock;
         cpll_s_q    <= cpll_meta_q;
         mmcm_meta_q <= mmcm_lock;
         mmcm_s_q    <= mmcm_meta_q;
         tx_meta_q   <= tx_done;
         tx_s_q      <= tx_meta_q;
         state_q     <= state_d;
         pulse_q     <= pulse_d;
         stable_q    <= stable_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         cpll_rst_q  <= cpll_rst_d;
         gtx_rst_q   <= gtx_rst_d;
         rdy_q       <= rdy_d;
         link_q      <= link_d;
         fault_q     <= fault_d;
      end
   end

`ifdef PFCLK_SEQ_LOSSCNT_EN
   logic [15:0] lockloss_q, lockloss_d;

   always_comb begin
      lockloss_d = lockloss_q;
      if (fail && state_q == StRun && lockloss_q != 16'hFFFF) lockloss_d = lockloss_q + 16'd1;
   end

   always_ff @(posedge clk_125) begin
      if (soft_reset) lockloss_q <= '0;
      else            lockloss_q <= lockloss_d;
   end

   assign lockloss_cnt = lockloss_q;
`endif

   assign cpll_reset_out = cpll_rst_q;
   assign gtx_reset_out  = gtx_rst_q;
   assign txuserrdy_out  = rdy_q;
   assign link_up        = link_q;
   assign fault          = fault_q;
   assign state_out      = state_q;
   assign retry_cnt      = retry_q;

endmodule

// File: tb/tb_pfclk_gtx_bringup_seq.sv
// Bench for pfclk_gtx_bringup_seq. A waveform of reset/lock inputs is built edge by edge
// (directed segments followed by a $urandom segment), an event-level model predicts the state
// after every edge, then the DUT is run and every edge plus a set of hand-derived points checked.

module tb_pfclk_gtx_bringup_seq;

   localparam int P = 4;
   localparam int S = 8;
   localparam int T = 100;
   localparam int M = 2;
   localparam int NMAX = 1400;

   localparam int IDLE = 0, CPLL_RST = 1, CPLL_WAIT = 2, MMCM_WAIT = 3;
   localparam int TX_RST = 4, TX_WAIT = 5, RUN = 6, FAULT = 7;

   logic clk_125 = 1'b0;
   always #4 clk_125 = ~clk_125;

   logic        soft_reset, cpll_lock, mmcm_lock, tx_done;
   logic        cpll_reset_out, gtx_reset_out, txuserrdy_out, link_up, fault;
   logic [2:0]  state_out;
   logic [3:0]  retry_cnt;
`ifdef PFCLK_SEQ_LOSSCNT_EN
   logic [15:0] lockloss_cnt;
`endif

   pfclk_gtx_bringup_seq #(
      .RST_PULSE_CYC    (P),
      .STABLE_CYC       (S),
      .LOCK_TIMEOUT_CYC (T),
      .MAX_RETRY        (M)
   ) dut (
      .clk_125        (clk_125),
      .soft_reset     (soft_reset),
      .cpll_lock      (cpll_lock),
      .mmcm_lock      (mmcm_lock),
      .tx_done        (tx_done),
      .cpll_reset_out (cpll_reset_out),
      .gtx_reset_out  (gtx_reset_out),
      .txuserrdy_out  (txuserrdy_out),
      .link_up        (link_up),
      .fault          (fault),
      .state_out      (state_out),
`ifdef PFCLK_SEQ_LOSSCNT_EN
      .retry_cnt      (retry_cnt),
      .lockloss_cnt   (lockloss_cnt)
`else
      .retry_cnt      (retry_cnt)
`endif
   );

   // Input value driven in the interval that ends at edge e.
   bit rst_w  [0:NMAX];
   bit cpll_w [0:NMAX];
   bit mmcm_w [0:NMAX];
   bit tx_w   [0:NMAX];
   int wp = 1;
   int n_edges;

   // Expected state / retry / lockloss after edge e.
   int exp_st [0:NMAX];
   int exp_rc [0:NMAX];
   int exp_lc [0:NMAX];

   logic [2:0]  obs_st [0:NMAX];
   logic [3:0]  obs_rc [0:NMAX];
   logic [4:0]  obs_o  [0:NMAX];
   logic [15:0] obs_lc [0:NMAX];

   int vectors = 0;
   int miscompares = 0;

   task automatic put(input bit r, input bit c, input bit m, input bit x);
      rst_w[wp]  = r;
      cpll_w[wp] = c;
      mmcm_w[wp] = m;
      tx_w[wp]   = x;
      wp++;
   endtask

   // Synchroniser view: value the sequencer acts on at edge e (two edges of delay,
   // zeroed by a reset at either of the two preceding edges).
   function automatic bit used(input int which, input int e);
      if (e < 3 || rst_w[e-1] || rst_w[e-2]) return 1'b0;
      case (which)
         0:       return cpll_w[e-2];
         1:       return mmcm_w[e-2];
         default: return tx_w[e-2];
      endcase
   endfunction

   function automatic int next_of(input int st);
      case (st)
         IDLE:      return CPLL_RST;
         CPLL_RST:  return CPLL_WAIT;
         CPLL_WAIT: return MMCM_WAIT;
         MMCM_WAIT: return TX_RST;
         TX_RST:    return TX_WAIT;
         TX_WAIT:   return RUN;
         default:   return st;
      endcase
   endfunction

   // {cpll_reset_out, gtx_reset_out, txuserrdy_out, link_up, fault} for each state.
   function automatic logic [4:0] out_of(input int st);
      case (st)
         IDLE, CPLL_RST:                return 5'b11000;
         CPLL_WAIT, MMCM_WAIT, TX_RST:  return 5'b01000;
         TX_WAIT:                       return 5'b00100;
         RUN:                           return 5'b00110;
         default:                       return 5'b11001;
      endcase
   endfunction

   // Edge at which a state entered at edge t is left (n_edges+1 if never), ignoring resets.
   task automatic find_exit(input int st, input int t, output int x, output bit failed);
      int  streak;
      int  e;
      bit  lost, watched;
      streak = 0;
      x      = n_edges + 1;
      failed = 1'b0;
      if (st == IDLE) begin
         x = t + 1;
         return;
      end
      if (st == CPLL_RST || st == TX_RST) begin
         x = t + P;
         return;
      end
      if (st == FAULT) return;
      for (int k = 1; t + k <= n_edges; k++) begin
         e = t + k;
         lost = (st == MMCM_WAIT && !used(0, e)) ||
                (st == TX_WAIT && !(used(0, e) && used(1, e))) ||
                (st == RUN && !(used(0, e) && used(1, e) && used(2, e)));
         watched = (st == CPLL_WAIT) ? used(0, e) :
                   (st == MMCM_WAIT) ? used(1, e) :
                   (st == TX_WAIT)   ? used(2, e) : 1'b0;
         streak = watched ? streak + 1 : 0;
         if (lost) begin
            x = e;
            failed = 1'b1;
            return;
         end
         if (st != RUN && streak >= S) begin
            x = e;
            return;
         end
         if (st != RUN && k >= T) begin
            x = e;
            failed = 1'b1;
            return;
         end
      end
   endtask

   task automatic fill(input int a, input int b, input int st, input int rc, input int lc);
      for (int e = a; e <= b && e <= n_edges; e++) begin
         exp_st[e] = st;
         exp_rc[e] = rc;
         exp_lc[e] = lc;
      end
   endtask

   task automatic plan();
      int t, st, rc, lc, x, r;
      bit failed;
      t  = 1;
      st = IDLE;
      rc = 0;
      lc = 0;
      while (t <= n_edges) begin
         find_exit(st, t, x, failed);
         r = t + 1;
         while (r <= n_edges && !rst_w[r]) r++;
         if (r <= n_edges && r <= x) begin
            fill(t, r - 1, st, rc, lc);
            t  = r;
            st = IDLE;
            rc = 0;
            lc = 0;
         end else begin
            fill(t, x - 1, st, rc, lc);
            t = x;
            if (failed) begin
               if (st == RUN && lc < 65535) lc++;
               rc = (rc < 15) ? rc + 1 : 15;
               st = (rc >= M) ? FAULT : CPLL_RST;
            end else begin
               st = next_of(st);
               if (st == RUN) rc = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input int e, input logic [15:0] got,
                      input logic [15:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, got, want);
      end
   endtask

   initial begin
      int s1, s2, s3, s4, s5, s6;
      logic [4:0] eo;

      // Clean bring-up.
      s1 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      repeat (48) put(0, 1, 1, 1);
      // One-cycle CPLL lock glitch at stable count 5.
      s2 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      for (int k = 2; k < 60; k++) put(0, (s2 + k) != (s2 + 10), 1, 1);
      // MMCM never locks: two timeouts then FAULT.
      s3 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      repeat (238) put(0, 1, 0, 1);
      // Reset out of FAULT, bring-up, then tx_done dropped for one cycle in RUN.
      s4 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      for (int k = 2; k < 130; k++) put(0, 1, 1, (s4 + k) != (s4 + 50));
      // soft_reset pulsed while in TX_WAIT.
      s5 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      for (int k = 2; k < 70; k++) put((s5 + k) == (s5 + 28), 1, 1, 1);
      // Random lock drops and occasional resets.
      s6 = wp;
      put(1, 1, 1, 1);
      put(1, 1, 1, 1);
      for (int k = 2; k < 600; k++)
         put($urandom_range(0, 199) == 0, $urandom_range(0, 127) != 0,
             $urandom_range(0, 127) != 0, $urandom_range(0, 127) != 0);
      n_edges = wp - 1;

      plan();

      for (int e = 1; e <= n_edges; e++) begin
         soft_reset = rst_w[e];
         cpll_lock  = cpll_w[e];
         mmcm_lock  = mmcm_w[e];
         tx_done    = tx_w[e];
         @(posedge clk_125);
         #1;
         obs_st[e] = state_out;
         obs_rc[e] = retry_cnt;
         obs_o[e]  = {cpll_reset_out, gtx_reset_out, txuserrdy_out, link_up, fault};
`ifdef PFCLK_SEQ_LOSSCNT_EN
         obs_lc[e] = lockloss_cnt;
`else
         obs_lc[e] = '0;
`endif
      end

      // Full trace against the model.
      for (int e = 1; e <= n_edges; e++) begin
         eo = out_of(exp_st[e]);
         chk("state_out", e, 16'(obs_st[e]), 16'(exp_st[e]));
         chk("retry_cnt", e, 16'(obs_rc[e]), 16'(exp_rc[e]));
         chk("cpll_reset_out", e, 16'(obs_o[e][4]), 16'(eo[4]));
         chk("gtx_reset_out", e, 16'(obs_o[e][3]), 16'(eo[3]));
         chk("txuserrdy_out", e, 16'(obs_o[e][2]), 16'(eo[2]));
         chk("link_up", e, 16'(obs_o[e][1]), 16'(eo[1]));
         chk("fault", e, 16'(obs_o[e][0]), 16'(eo[0]));
`ifdef PFCLK_SEQ_LOSSCNT_EN
         chk("lockloss_cnt", e, obs_lc[e], 16'(exp_lc[e]));
`endif
      end

      // Clean bring-up, hand-derived edges.
      chk("clean_reset_state", s1 + 1, 16'(obs_st[s1 + 1]), 16'(IDLE));
      chk("clean_reset_outs", s1 + 1, 16'(obs_o[s1 + 1]), 16'(5'b11000));
      chk("clean_reset_retry", s1 + 1, 16'(obs_rc[s1 + 1]), 16'd0);
      chk("clean_cpll_rst_first", s1 + 2, 16'(obs_st[s1 + 2]), 16'(CPLL_RST));
      chk("clean_cpll_rst_last", s1 + 5, 16'(obs_o[s1 + 5][4]), 16'd1);
      chk("clean_cpll_rst_drop", s1 + 6, 16'(obs_o[s1 + 6][4]), 16'd0);
      chk("clean_cpll_wait", s1 + 6, 16'(obs_st[s1 + 6]), 16'(CPLL_WAIT));
      chk("clean_mmcm_wait", s1 + 14, 16'(obs_st[s1 + 14]), 16'(MMCM_WAIT));
      chk("clean_tx_rst", s1 + 22, 16'(obs_st[s1 + 22]), 16'(TX_RST));
      chk("clean_tx_wait", s1 + 26, 16'(obs_st[s1 + 26]), 16'(TX_WAIT));
      chk("clean_tx_wait_last", s1 + 33, 16'(obs_st[s1 + 33]), 16'(TX_WAIT));
      chk("clean_run", s1 + 34, 16'(obs_st[s1 + 34]), 16'(RUN));
      chk("clean_link_by_40", s1 + 41, 16'(obs_o[s1 + 41][1]), 16'd1);
      chk("clean_retry", s1 + 41, 16'(obs_rc[s1 + 41]), 16'd0);

      // Glitch restarts the stable count.
      chk("glitch_still_cpll_wait", s2 + 19, 16'(obs_st[s2 + 19]), 16'(CPLL_WAIT));
      chk("glitch_mmcm_wait", s2 + 20, 16'(obs_st[s2 + 20]), 16'(MMCM_WAIT));
      chk("glitch_no_retry", s2 + 20, 16'(obs_rc[s2 + 20]), 16'd0);

      // Timeouts and FAULT.
      chk("tmo1_last_wait", s3 + 113, 16'(obs_st[s3 + 113]), 16'(MMCM_WAIT));
      chk("tmo1_retry_state", s3 + 114, 16'(obs_st[s3 + 114]), 16'(CPLL_RST));
      chk("tmo1_retry_cnt", s3 + 114, 16'(obs_rc[s3 + 114]), 16'd1);
      chk("tmo2_last_wait", s3 + 225, 16'(obs_st[s3 + 225]), 16'(MMCM_WAIT));
      chk("tmo2_fault_state", s3 + 226, 16'(obs_st[s3 + 226]), 16'(FAULT));
      chk("tmo2_fault_outs", s3 + 226, 16'(obs_o[s3 + 226]), 16'(5'b11001));
      chk("tmo2_retry_cnt", s3 + 226, 16'(obs_rc[s3 + 226]), 16'd2);

      // Reset out of FAULT.
      chk("fault_sticky", s4 - 1, 16'(obs_st[s4 - 1]), 16'(FAULT));
      chk("fault_reset_state", s4, 16'(obs_st[s4]), 16'(IDLE));
      chk("fault_reset_outs", s4, 16'(obs_o[s4]), 16'(5'b11000));
      chk("fault_reset_retry", s4, 16'(obs_rc[s4]), 16'd0);

      // Loss in RUN.
      chk("loss_link_before", s4 + 51, 16'(obs_o[s4 + 51][1]), 16'd1);
      chk("loss_link_drop", s4 + 52, 16'(obs_o[s4 + 52][1]), 16'd0);
      chk("loss_rdy_drop", s4 + 52, 16'(obs_o[s4 + 52][2]), 16'd0);
      chk("loss_state", s4 + 52, 16'(obs_st[s4 + 52]), 16'(CPLL_RST));
      chk("loss_retry", s4 + 52, 16'(obs_rc[s4 + 52]), 16'd1);
      chk("loss_rerun", s4 + 84, 16'(obs_st[s4 + 84]), 16'(RUN));
      chk("loss_retry_clear", s4 + 84, 16'(obs_rc[s4 + 84]), 16'd0);
`ifdef PFCLK_SEQ_LOSSCNT_EN
      chk("loss_lockloss_cnt", s4 + 84, obs_lc[s4 + 84], 16'd1);
`endif

      // Reset during TX_WAIT.
      chk("midrst_before", s5 + 27, 16'(obs_st[s5 + 27]), 16'(TX_WAIT));
      chk("midrst_state", s5 + 28, 16'(obs_st[s5 + 28]), 16'(IDLE));
      chk("midrst_outs", s5 + 28, 16'(obs_o[s5 + 28]), 16'(5'b11000));
      chk("midrst_retry", s5 + 28, 16'(obs_rc[s5 + 28]), 16'd0);
      chk("midrst_restart", s5 + 29, 16'(obs_st[s5 + 29]), 16'(CPLL_RST));
      chk("random_seg_reset", s6 + 1, 16'(obs_st[s6 + 1]), 16'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
